// File: rtl/tdp_blockram.sv
// True dual-port block RAM: byte enables, 1- or 2-cycle read latency, read-valid strobes and
// write-collision detection (port A wins). Define TDP_RDW_BYPASS_EN for new-data read-during-write.
module tdp_blockram #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned BYTE_W       = 8,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned NB          = WIDTH / BYTE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_en,
  input  logic             a_we,
  input  logic [NB-1:0]    a_be,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  output logic             a_rvalid,
  input  logic             b_en,
  input  logic             b_we,
  input  logic [NB-1:0]    b_be,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic [WIDTH-1:0] b_rdata,
  output logic             b_rvalid,
  output logic             collision,
  output logic [15:0]      collision_cnt
);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("tdp_blockram: READ_LATENCY must be 1 or 2");
  end
  if (WIDTH % BYTE_W != 0) begin : g_bad_width
    $error("tdp_blockram: WIDTH must be a multiple of BYTE_W");
  end

  localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            rd, wr, in_rng;
  logic [1:0][AW-1:0]    addr;
  logic [1:0][NB-1:0]    be;
  logic [1:0][WIDTH-1:0] wdata, rword;
  logic [1:0][WIDTH-1:0] s1_q, s1_d;
  logic [1:0]            v1_q, v1_d;
  logic                  collision_q, collision_d;
  logic [15:0]           collision_cnt_q, collision_cnt_d;

  assign rd     = {b_en & ~b_we, a_en & ~a_we};
  assign wr     = {b_en & b_we, a_en & a_we};
  assign addr   = {b_addr, a_addr};
  assign be     = {b_be, a_be};
  assign wdata  = {b_wdata, a_wdata};
  assign in_rng = {({1'b0, b_addr} < DepthW), ({1'b0, a_addr} < DepthW)};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rword[p] = '0;
      if (in_rng[p]) rword[p] = mem[addr[p]];
`ifdef TDP_RDW_BYPASS_EN
      // Lanes written this cycle by the other port replace the stored lanes.
      if (in_rng[p] && wr[1-p] && addr[1-p] == addr[p]) begin
        for (int i = 0; i < NB; i++) begin
          if (be[1-p][i]) rword[p][i*BYTE_W +: BYTE_W] = wdata[1-p][i*BYTE_W +: BYTE_W];
        end
      end
`endif
      s1_d[p] = rd[p] ? rword[p] : s1_q[p];
      v1_d[p] = rd[p];
    end
  end

  always_comb begin
    collision_d     = wr[0] & wr[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));
    collision_cnt_d = collision_cnt_q;
    if (collision_d && collision_cnt_q != 16'hFFFF) collision_cnt_d = collision_cnt_q + 16'd1;
  end

  // Port B lanes are scheduled first so overlapping port A lanes override them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int p = 1; p >= 0; p--) begin
        if (wr[p] && in_rng[p]) begin
          for (int i = 0; i < NB; i++) begin
            if (be[p][i]) mem[addr[p]][i*BYTE_W +: BYTE_W] <= wdata[p][i*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q            <= '0;
      v1_q            <= '0;
      collision_q     <= 1'b0;
      collision_cnt_q <= '0;
    end else begin
      s1_q            <= s1_d;
      v1_q            <= v1_d;
      collision_q     <= collision_d;
      collision_cnt_q <= collision_cnt_d;
    end
  end

  assign collision     = collision_q;
  assign collision_cnt = collision_cnt_q;

  if (READ_LATENCY == 1) begin : g_lat1
    assign a_rdata  = s1_q[0];
    assign b_rdata  = s1_q[1];
    assign a_rvalid = v1_q[0];
    assign b_rvalid = v1_q[1];
  end else begin : g_lat2
    logic [1:0][WIDTH-1:0] s2_q, s2_d;
    logic [1:0]            v2_q, v2_d;

    always_comb begin
      for (int p = 0; p < 2; p++) s2_d[p] = v1_q[p] ? s1_q[p] : s2_q[p];
      v2_d = v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_q <= '0;
        v2_q <= '0;
      end else begin
        s2_q <= s2_d;
        v2_q <= v2_d;
      end
    end

    assign a_rdata  = s2_q[0];
    assign b_rdata  = s2_q[1];
    assign a_rvalid = v2_q[0];
    assign b_rvalid = v2_q[1];
  end

endmodule

// File: doc/tdp_blockram.md
Name: tdp_blockram

Overview:
- Parametrised true dual-port block RAM, successor to the simple one-write/one-read dual-port RAM.
- Both ports A and B read and write independently on one clock.
- Adds per-byte write enables, a selectable read latency of 1 or 2 cycles, and read-valid strobes.
- Detects same-address write collisions with fixed port-A priority; used as shared buffer memory between two datapath clients.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of BYTE_W.
- DEPTH, 1024, number of words; need not be a power of two.
- BYTE_W, 8, bits per byte-enable lane.
- READ_LATENCY, 1, cycles from read request to data; legal values 1 or 2, elaboration error otherwise.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- NB, WIDTH/BYTE_W, byte-lane count (derived).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_en  in  1  port A request.
- a_we  in  1  port A write (1) / read (0); qualified by a_en.
- a_be  in  NB  port A byte enables; write only.
- a_addr  in  AW  port A word address.
- a_wdata  in  WIDTH  port A write data.
- a_rdata  out  WIDTH  port A read data.
- a_rvalid  out  1  one-cycle strobe marking a_rdata valid.
- b_en, b_we, b_be, b_addr, b_wdata, b_rdata, b_rvalid  (same as port A, for port B).
- collision  out  1  one-cycle pulse: same-cycle overlapping byte writes to one address.
- collision_cnt  out  16  saturating collision count.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, collision=0, collision_cnt=0; read pipelines are flushed.
- Memory array is not reset; its contents persist across reset.
- While rst_n=0, requests are ignored: no writes, no reads.
- Write (x_en=1, x_we=1): at the rising edge, each lane i with x_be[i]=1 stores x_wdata lane i; other lanes are unchanged.
  - x_be=0 is a legal no-op write.
  - A write never produces x_rvalid.
- Read (x_en=1, x_we=0), issued at edge N:
  - READ_LATENCY=1: x_rdata updates and x_rvalid=1 after edge N.
  - READ_LATENCY=2: x_rdata updates and x_rvalid=1 after edge N+1, via an output register stage.
  - Full throughput: one read per cycle per port; the valid pipeline is a 1- or 2-deep shift of request flags.
  - x_rdata holds its last value while x_rvalid=0.
- Address >= DEPTH (non-power-of-two DEPTH only): write discarded; read returns 0 with normal x_rvalid timing.
- Same-address write/write in one cycle:
  - Per lane, port A wins where both a_be and b_be are set.
  - Lanes enabled by one port only take that port's data.
  - If any lane overlaps, collision pulses the following cycle and collision_cnt increments, saturating at 16'hFFFF.
  - Non-overlapping byte sets do not count as a collision.
- Same-address read on one port, write on the other, same cycle: the read returns the pre-write word unless the bypass feature below is enabled.
- Both ports reading the same address: both get identical data, no collision.
- Reset asserted mid-read: the in-flight x_rvalid is dropped immediately and never emitted after release.

Optional Feature:
- Macro: TDP_RDW_BYPASS_EN.
- Defined: a read colliding with a same-cycle write from the other port returns the post-write word. Written lanes take the writer's data; unwritten lanes take the stored data. On a double write, port A's priority is applied first. Latency is unchanged.
- Undefined: old-data semantics as stated in Behaviour. No extra bypass logic is generated.

Test Plan:
- READ_LATENCY=1: A writes 16'hABCD to addr 10 (a_be=2'b11); next cycle B reads 10 -> b_rvalid one cycle later, b_rdata=16'hABCD.
- Byte enables: A writes 16'h1234 to addr 11; A writes 16'hFF00 to addr 11 with a_be=2'b10; B reads 11 -> 16'hFF34.
- Write collision: same cycle, A writes 16'hAAAA with be=2'b11 and B writes 16'h5555 with be=2'b01, both to addr 20; read 20 -> 16'hAAAA; collision=1 for one cycle; collision_cnt=1. Repeat with a_be=2'b10, b_be=2'b01 -> 16'hAA55, no collision.
- READ_LATENCY=2 streaming: B reads addrs 0..7 back-to-back (preloaded with data = addr) -> b_rvalid high 8 consecutive cycles starting 2 cycles after the first request, data 0..7 in order.
- Read-during-write: addr 30 holds 16'h1111; A writes 16'h2222 while B reads 30 -> b_rdata=16'h1111 without TDP_RDW_BYPASS_EN, 16'h2222 with it.
- Reset mid-read: B issues a read, rst_n pulled low before data returns -> b_rvalid and b_rdata go 0 at once; after release, no stale strobe; addr 10 still reads 16'hABCD.
